// File: rtl/sram_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sram_req_arbiter                                                  |
// | Desc   : NREQ-to-1 sram-like request arbiter with in-order response        |
// |          routing through an owner-ID FIFO. Define ARB_RR_EN for            |
// |          round-robin arbitration instead of fixed priority.                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sram_req_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           s_req,
  input  logic [NREQ-1:0]           s_wr,
  input  logic [2*NREQ-1:0]         s_size,
  input  logic [32*NREQ-1:0]        s_addr,
  input  logic [32*NREQ-1:0]        s_wdata,
  input  logic [4*NREQ-1:0]         s_wstrb,
  output logic [NREQ-1:0]           s_addr_ok,
  output logic [NREQ-1:0]           s_data_ok,
  output logic [31:0]               s_rdata,
  output logic                      m_req,
  output logic                      m_wr,
  output logic [1:0]                m_size,
  output logic [31:0]               m_addr,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  input  logic                      m_addr_ok,
  input  logic                      m_data_ok,
  input  logic [31:0]               m_rdata,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [c_GW-1:0] w_gnt;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  logic [c_GW-1:0] r_ids [DEPTH];
  logic [c_AW-1:0] r_wp;
  logic [c_AW-1:0] r_rp;
  logic [c_AW:0]   r_count;
  logic            r_err;

  assign w_full = (r_count == (c_AW+1)'(DEPTH));
  assign m_req  = (|s_req) && !w_full;
  assign w_push = m_req && m_addr_ok;
  assign w_pop  = m_data_ok && (r_count != '0);

`ifdef ARB_RR_EN
  logic [c_GW-1:0]   r_rr_ptr;
  logic [2*NREQ-1:0] w_rot;
  logic [c_GW:0]     w_idx;

  // Rotating the doubled request vector puts the pointer's master at bit 0.
  assign w_rot = {s_req, s_req} >> r_rr_ptr;

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (c_GW+1)'(k);
      if (w_idx >= (c_GW+1)'(NREQ)) w_idx = w_idx - (c_GW+1)'(NREQ);
      if (w_rot[k]) w_gnt = w_idx[c_GW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_gnt == c_GW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
    end
  end
`else
  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (s_req[i]) w_gnt = c_GW'(i);
    end
  end
`endif

  always_comb begin
    m_wr    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (m_req && (w_gnt == c_GW'(i))) begin
        m_wr    = s_wr[i];
        m_size  = s_size[2*i +: 2];
        m_addr  = s_addr[32*i +: 32];
        m_wdata = s_wdata[32*i +: 32];
        m_wstrb = s_wstrb[4*i +: 4];
      end
    end
  end

  always_comb begin
    s_addr_ok = '0;
    s_data_ok = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_addr_ok[i] = w_push && (w_gnt == c_GW'(i));
      s_data_ok[i] = w_pop && (r_ids[r_rp] == c_GW'(i));
    end
  end

  assign s_rdata     = m_rdata;
  assign outstanding = r_count;
  assign err         = r_err;

  // Owner storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_ids[r_wp] <= w_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (m_data_ok && (r_count == '0)) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sram_req_arbiter                                               |
// | Desc   : Randomized self-checking bench for sram_req_arbiter against a     |
// |          queue-based reference model (honours ARB_RR_EN).                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sram_req_arbiter;

  localparam int NREQ   = 2;
  localparam int DEPTH  = 4;
  localparam int CYCLES = 4000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        s_req;
  logic [NREQ-1:0]        s_wr;
  logic [2*NREQ-1:0]      s_size;
  logic [32*NREQ-1:0]     s_addr;
  logic [32*NREQ-1:0]     s_wdata;
  logic [4*NREQ-1:0]      s_wstrb;
  logic [NREQ-1:0]        s_addr_ok;
  logic [NREQ-1:0]        s_data_ok;
  logic [31:0]            s_rdata;
  logic                   m_req;
  logic                   m_wr;
  logic [1:0]             m_size;
  logic [31:0]            m_addr;
  logic [31:0]            m_wdata;
  logic [3:0]             m_wstrb;
  logic                   m_addr_ok;
  logic                   m_data_ok;
  logic [31:0]            m_rdata;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err;

  sram_req_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: list of owners in acceptance order, sticky error, RR pointer.
  int owners[$];
  bit mdl_err;
  int mdl_ptr;

  function automatic int pick_master(input logic [NREQ-1:0] req, input int ptr);
    int g;
    g = -1;
`ifdef ARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && req[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (g < 0 && req[i]) g = i;
    end
`endif
    return g;
  endfunction

  task automatic drive_random(input int phase);
    int p_data;
    s_req   = NREQ'($urandom_range(0, (1 << NREQ) - 1));
    s_wr    = NREQ'($urandom);
    s_size  = (2*NREQ)'($urandom);
    s_wstrb = (4*NREQ)'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      s_addr[32*i +: 32]  = $urandom;
      s_wdata[32*i +: 32] = $urandom;
    end
    m_addr_ok = ($urandom_range(0, 99) < 70);
    // Alternate fill-heavy and drain-heavy phases to reach both full and empty.
    p_data    = (phase % 2 == 0) ? 15 : 70;
    m_data_ok = ($urandom_range(0, 99) < p_data);
    m_rdata   = $urandom;
    rst       = ($urandom_range(0, 199) == 0);
    if (rst) begin
      s_req     = '0;
      m_data_ok = 1'b0;
    end
  endtask

  task automatic check_cycle();
    int g;
    bit full, exp_mreq, exp_push, exp_pop;
    logic [NREQ-1:0] exp_aok, exp_dok;
    logic [38:0] exp_ctl;
    full     = (owners.size() == DEPTH);
    g        = pick_master(s_req, mdl_ptr);
    exp_mreq = (g >= 0) && !full;
    exp_push = exp_mreq && m_addr_ok;
    exp_pop  = m_data_ok && (owners.size() > 0);
    exp_aok  = '0;
    exp_dok  = '0;
    if (exp_push) exp_aok[g] = 1'b1;
    if (exp_pop)  exp_dok[owners[0]] = 1'b1;
    exp_ctl = '0;
    if (exp_mreq) exp_ctl = {s_wr[g], s_size[2*g +: 2], s_wstrb[4*g +: 4], s_addr[32*g +: 32]};
    chk("m_req", 64'(m_req), 64'(exp_mreq));
    chk("m_fields", 64'({m_wr, m_size, m_wstrb, m_addr}), 64'(exp_ctl));
    chk("m_wdata", 64'(m_wdata), exp_mreq ? 64'(s_wdata[32*g +: 32]) : 64'd0);
    chk("s_addr_ok", 64'(s_addr_ok), 64'(exp_aok));
    chk("s_data_ok", 64'(s_data_ok), 64'(exp_dok));
    if (exp_pop) chk("s_rdata", 64'(s_rdata), 64'(m_rdata));
    chk("outstanding", 64'(outstanding), 64'(owners.size()));
    chk("err", 64'(err), 64'(mdl_err));
  endtask

  task automatic model_step();
    int g;
    bit exp_push, exp_pop, was_empty;
    if (rst) begin
      owners.delete();
      mdl_err = 1'b0;
      mdl_ptr = 0;
      return;
    end
    g         = pick_master(s_req, mdl_ptr);
    exp_push  = (g >= 0) && (owners.size() < DEPTH) && m_addr_ok;
    was_empty = (owners.size() == 0);
    exp_pop   = m_data_ok && !was_empty;
    if (m_data_ok && was_empty) mdl_err = 1'b1;
    if (exp_pop) void'(owners.pop_front());
    if (exp_push) begin
      owners.push_back(g);
      mdl_ptr = (g + 1) % NREQ;
    end
  endtask

  initial begin
    rst = 1'b1; s_req = '0; s_wr = '0; s_size = '0; s_addr = '0;
    s_wdata = '0; s_wstrb = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    owners.delete(); mdl_err = 1'b0; mdl_ptr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_m_req", 64'(m_req), 64'd0);
    chk("reset_s_ok", 64'({s_addr_ok, s_data_ok}), 64'd0);
    @(posedge clk);
    for (int c = 0; c < CYCLES; c++) begin
      #1 drive_random(c / 40);
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      model_step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one downstream sram-like port among NREQ upstream sram-like masters, e.g. the IF/IW instruction fetch path and the MEM data path, ahead of the AXI bridge.
- Arbitrates address-phase requests.
- Records the owner of each accepted request in an in-order ID FIFO.
- Routes each data_ok/rdata response back to the master that issued it. The downstream port returns responses in request order.

Parameters:
- NREQ, 2, number of upstream masters; index NREQ-1 has highest fixed priority (data port = 1, inst = 0).
- DEPTH, 4, maximum outstanding accepted requests awaiting data_ok; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_req  in  NREQ  per-master request valid
- s_wr  in  NREQ  per-master write flag
- s_size  in  2*NREQ  packed access size, master i at [2i+1:2i]
- s_addr  in  32*NREQ  packed address
- s_wdata  in  32*NREQ  packed write data
- s_wstrb  in  4*NREQ  packed byte strobes
- s_addr_ok  out  NREQ  per-master request accepted
- s_data_ok  out  NREQ  per-master response valid
- s_rdata  out  32  response data, shared, valid where s_data_ok is set
- m_req  out  1  downstream request
- m_wr, m_size, m_addr, m_wdata, m_wstrb  out  1/2/32/32/4  muxed fields of the granted master
- m_addr_ok  in  1  downstream accepted request
- m_data_ok  in  1  downstream response
- m_rdata  in  32  downstream read data
- outstanding  out  clog2(DEPTH)+1  current ID FIFO occupancy
- err  out  1  sticky protocol error flag

Behaviour:
- Reset: ID FIFO emptied; outstanding=0; err=0; RR pointer=0; all s_addr_ok/s_data_ok=0; m_req=0. Reset mid-transaction drops all pending ownership. Downstream is reset in the same cycle.
- Grant (combinational): with `full=(outstanding==DEPTH)`, the granted master is the highest-index i with s_req[i]=1 when !full.
  - m_req = |s_req && !full.
  - m_* fields mux from the granted master; when m_req=0, the fields are 0.
- Handshake:
  - s_addr_ok[g] = m_req && m_addr_ok; all other bits are 0.
  - Address-phase handshake completes on m_req && m_addr_ok. This pushes ID g into the FIFO at the posedge.
  - Ungranted masters hold their request; the arbiter buffers no address-phase data.
- Response:
  - When m_data_ok=1 and the FIFO is non-empty, head ID h is popped at the posedge.
  - s_data_ok[h]=1 combinationally in that cycle; s_rdata=m_rdata.
  - Zero added latency on both phases.
- Simultaneous push and pop:
  - When not full, both happen; occupancy is unchanged.
  - When full, no push occurs (m_req is already 0), even if a pop occurs that same cycle. The push retries next cycle.
- Empty boundary: m_data_ok=1 with occupancy 0 sets err=1 (sticky until rst). No pop occurs, no s_data_ok fires, and occupancy stays 0.
- Wrap-around: FIFO read/write pointers are clog2(DEPTH) bits and wrap naturally. Occupancy is tracked separately.
- Writes and reads share the ID FIFO. A write's data_ok is routed exactly like a read's.
- Request stability: the arbiter does not lock a grant across cycles. A master that drops s_req before addr_ok simply loses the slot.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration replaces fixed priority.
  - Pointer p (clog2(NREQ) bits) starts at 0. The grant is the first i with s_req[i] searching p, p+1, ... modulo NREQ.
  - After each completed address handshake to master g, p <= (g+1) mod NREQ.
  - p does not change without a handshake.
- ARB_RR_EN undefined: fixed priority as above; no pointer register is built.

Test Plan:
- Single read: s_req=2'b01, addr 0x1c000000 → m_req=1 and m_addr=0x1c000000. With m_addr_ok=1 → s_addr_ok=2'b01 and outstanding=1. m_data_ok with m_rdata=0x02800413 two cycles later → s_data_ok=2'b01, s_rdata=0x02800413, outstanding=0.
- Contention, fixed priority: s_req=2'b11 with m_addr_ok=1 for 2 cycles → cycle 1 grants master 1, cycle 2 grants master 1 again if it still requests. Responses A, B → s_data_ok=2'b10 for both.
- Interleaved ownership: accept inst, data, inst (outstanding=3); three m_data_ok → s_data_ok sequence 01, 10, 01 with matching rdata.
- Full: DEPTH=4 accepted with no response → m_req=0 and s_addr_ok=0 despite s_req. The m_data_ok in that cycle pops and sets outstanding=3; next cycle m_req=1.
- Spurious response at outstanding=0 → err=1, s_data_ok=0, and err stays 1 until rst. Asserting rst with 2 outstanding → outstanding=0 next cycle.
- ARB_RR_EN: s_req=2'b11 held, m_addr_ok=1 for 4 cycles → grants 0, 1, 0, 1. Without the macro → grants 1, 1, 1, 1.
